// File: rtl/fifo_dwc_pkg.sv
// Shared widths and pointer-width derivations for the 64-in / 32-out width-converting FIFO.
package fifo_dwc_pkg;

   localparam int WR_DATA_W        = 64;
   localparam int RD_DATA_W        = 32;
   localparam int DEF_DEPTH_W      = 9;
   localparam int DEF_ALMOST_FULL  = 508;
   localparam int DEF_ALMOST_EMPTY = 4;

   // The extra MSB on each pointer separates full from empty; the read side counts half-words.
   function automatic int wr_ptr_w(input int depth_w);
      return depth_w + 1;
   endfunction

   function automatic int rd_ptr_w(input int depth_w);
      return depth_w + 2;
   endfunction

endpackage

// File: rtl/fifo_dwc_sdpram.sv
// Simple dual-port RAM with a registered read port; contents are never reset.
module fifo_dwc_sdpram
   import fifo_dwc_pkg::*;
#(
   parameter int ADDR_W = DEF_DEPTH_W,
   parameter int DATA_W = WR_DATA_W
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/fifo_64i_32o_dwc.sv
// Single-clock FIFO accepting 64-bit words and returning them as two 32-bit halves, low half first.
module fifo_64i_32o_dwc
   import fifo_dwc_pkg::*;
#(
   parameter int WR_DEPTH_WIDTH   = DEF_DEPTH_W,
   parameter int ALMOST_FULL_NUM  = DEF_ALMOST_FULL,
   parameter int ALMOST_EMPTY_NUM = DEF_ALMOST_EMPTY
) (
   input  logic                      clk,
   input  logic                      tb_rst,
   input  logic [WR_DATA_W-1:0]      wr_data,
   input  logic                      wr_en,
   output logic                      wr_full,
   output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
   output logic                      almost_full,
   input  logic                      rd_en,
   output logic [RD_DATA_W-1:0]      rd_data,
   output logic                      rd_empty,
   output logic [WR_DEPTH_WIDTH+1:0] rd_water_level,
   output logic                      almost_empty
);

   localparam int WP_W = wr_ptr_w(WR_DEPTH_WIDTH);
   localparam int RP_W = rd_ptr_w(WR_DEPTH_WIDTH);

   logic [WP_W-1:0]      wr_ptr;
   logic [RP_W-1:0]      rd_ptr;
   logic                 wr_acc_p0;
   logic                 rd_acc_p0;
   logic                 sel_p1;
   logic                 vld_p1;
   logic [WR_DATA_W-1:0] ram_q_p1;

   // Stage p0: accept decisions come from the pre-edge flags only.
   assign wr_acc_p0 = wr_en && !wr_full;
   assign rd_acc_p0 = rd_en && !rd_empty;

   // The write slot is only freed once rd_ptr moves past its upper half.
   assign rd_water_level = {wr_ptr, 1'b0} - rd_ptr;
   assign wr_water_level = wr_ptr - rd_ptr[RP_W-1:1];
   assign wr_full        = (wr_water_level == {1'b1, {WR_DEPTH_WIDTH{1'b0}}});
   assign rd_empty       = (rd_water_level == '0);
   assign almost_full    = (wr_water_level >= WP_W'(ALMOST_FULL_NUM));
   assign almost_empty   = (rd_water_level <= RP_W'(ALMOST_EMPTY_NUM));

   always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         sel_p1 <= 1'b0;
         vld_p1 <= 1'b0;
      end else begin
         if (wr_acc_p0) wr_ptr <= wr_ptr + WP_W'(1);
         if (rd_acc_p0) begin
            rd_ptr <= rd_ptr + RP_W'(1);
            sel_p1 <= rd_ptr[0];
            vld_p1 <= 1'b1;
         end
      end
   end

   fifo_dwc_sdpram #(
      .ADDR_W (WR_DEPTH_WIDTH),
      .DATA_W (WR_DATA_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_acc_p0),
      .wr_addr (wr_ptr[WR_DEPTH_WIDTH-1:0]),
      .wr_data (wr_data),
      .rd_en   (rd_acc_p0),
      .rd_addr (rd_ptr[RP_W-2:1]),
      .rd_data (ram_q_p1)
   );

   // Stage p1: RAM word and half-select are both registered on the accepting edge, so rd_data holds between reads.
   assign rd_data = !vld_p1 ? '0 :
                    sel_p1  ? ram_q_p1[WR_DATA_W-1:RD_DATA_W] : ram_q_p1[RD_DATA_W-1:0];

endmodule

// File: tb/tb_fifo_64i_32o_dwc.sv
// Directed bench for fifo_64i_32o_dwc: reset, single word, fill/drain, wrap, concurrent access, mid-run reset.
module tb_fifo_64i_32o_dwc;

   logic        clk = 1'b0;
   logic        tb_rst = 1'b1;
   logic [63:0] wr_data = '0;
   logic        wr_en = 1'b0;
   logic        wr_full;
   logic [9:0]  wr_water_level;
   logic        almost_full;
   logic        rd_en = 1'b0;
   logic [31:0] rd_data;
   logic        rd_empty;
   logic [10:0] rd_water_level;
   logic        almost_empty;

   int tests = 0;
   int fails = 0;
   logic [31:0] model [$];

   fifo_64i_32o_dwc dut (
      .clk            (clk),
      .tb_rst         (tb_rst),
      .wr_data        (wr_data),
      .wr_en          (wr_en),
      .wr_full        (wr_full),
      .wr_water_level (wr_water_level),
      .almost_full    (almost_full),
      .rd_en          (rd_en),
      .rd_data        (rd_data),
      .rd_empty       (rd_empty),
      .rd_water_level (rd_water_level),
      .almost_empty   (almost_empty)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [63:0] d);
      wr_en = 1'b1;
      wr_data = d;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic rd();
      rd_en = 1'b1;
      @(posedge clk); #1;
      rd_en = 1'b0;
   endtask

   function automatic void push_word(input logic [63:0] d);
      model.push_back(d[31:0]);
      model.push_back(d[63:32]);
   endfunction

   initial begin
      logic [63:0] d;
      logic [31:0] exp;
      int          rem;

      // reset applies before any clock edge
      #1;
      chk("rst_empty", rd_empty, 1);
      chk("rst_aempty", almost_empty, 1);
      chk("rst_full", wr_full, 0);
      chk("rst_afull", almost_full, 0);
      chk("rst_wlvl", wr_water_level, 0);
      chk("rst_rlvl", rd_water_level, 0);
      chk("rst_rdata", rd_data, 0);
      #199;
      tb_rst = 1'b0;

      // single word
      wr(64'hA5A5_0001_5A5A_0002);
      chk("sw_rlvl", rd_water_level, 2);
      chk("sw_wlvl", wr_water_level, 1);
      rd();
      chk("sw_rd0", rd_data, 32'h5A5A_0002);
      chk("sw_wlvl1", wr_water_level, 1);
      chk("sw_rlvl1", rd_water_level, 1);
      rd();
      chk("sw_rd1", rd_data, 32'hA5A5_0001);
      chk("sw_empty", rd_empty, 1);
      chk("sw_wlvl2", wr_water_level, 0);

      // fill with 513 down-counting words; the last one must be dropped
      for (int i = 0; i < 513; i++) begin
         d = 64'hFFFF_FFFF_FFFF_FFFF - 64'(i);
         wr(d);
         if (i < 512) push_word(d);
         chk("fill_wlvl", wr_water_level, (i + 1 > 512) ? 512 : i + 1);
         chk("fill_afull", almost_full, (i + 1 >= 508) ? 1 : 0);
         chk("fill_full", wr_full, (i + 1 >= 512) ? 1 : 0);
      end
      chk("fill_rlvl", rd_water_level, 1024);

      exp = '0;
      for (int j = 1; j <= 1024; j++) begin
         exp = model.pop_front();
         rd();
         rem = 1024 - j;
         chk("drain_data", rd_data, exp);
         chk("drain_aempty", almost_empty, (rem <= 4) ? 1 : 0);
         chk("drain_wlvl", wr_water_level, (rem + 1) / 2);
      end
      chk("drain_empty", rd_empty, 1);
      rd();
      chk("drain_hold", rd_data, exp);
      chk("drain_rlvl", rd_water_level, 0);

      // three wrap passes across the pointer MSB
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 512; i++) begin
            d = {$urandom, $urandom};
            wr(d);
            push_word(d);
         end
         chk("wrap_full", wr_full, 1);
         for (int j = 0; j < 1024; j++) begin
            exp = model.pop_front();
            rd();
            chk("wrap_data", rd_data, exp);
         end
         chk("wrap_empty", rd_empty, 1);
      end

      // concurrent read/write from level 10
      for (int i = 0; i < 5; i++) begin
         d = {32'hC0DE_0000 + 32'(i), 32'h1000_0000 + 32'(i)};
         wr(d);
         push_word(d);
      end
      chk("cc_start", rd_water_level, 10);
      for (int n = 1; n <= 50; n++) begin
         d = {32'hBEEF_0000 + 32'(n), 32'h2000_0000 + 32'(n)};
         exp = model.pop_front();
         push_word(d);
         wr_en = 1'b1;
         rd_en = 1'b1;
         wr_data = d;
         @(posedge clk); #1;
         chk("cc_data", rd_data, exp);
         chk("cc_rlvl", rd_water_level, 10 + n);
      end
      wr_en = 1'b0;
      rd_en = 1'b0;
      while (model.size() > 0) begin
         exp = model.pop_front();
         rd();
         chk("cc_drain", rd_data, exp);
      end
      chk("cc_empty", rd_empty, 1);

      // mid-operation reset with reads active
      for (int i = 0; i < 100; i++) begin
         d = {32'h3000_0000 + 32'(i), 32'h4000_0000 + 32'(i)};
         wr(d);
         push_word(d);
      end
      for (int j = 0; j < 3; j++) begin
         exp = model.pop_front();
         rd();
         chk("mr_pre", rd_data, exp);
      end
      rd_en = 1'b1;
      #2;
      tb_rst = 1'b1;
      #1;
      chk("mr_empty", rd_empty, 1);
      chk("mr_rlvl", rd_water_level, 0);
      chk("mr_wlvl", wr_water_level, 0);
      chk("mr_rdata", rd_data, 0);
      @(posedge clk); #1;
      rd_en = 1'b0;
      #2;
      tb_rst = 1'b0;
      model.delete();
      @(negedge clk);
      wr(64'h1234_5678_9ABC_DEF0);
      rd();
      chk("mr_new0", rd_data, 32'h9ABC_DEF0);
      rd();
      chk("mr_new1", rd_data, 32'h1234_5678);
      chk("mr_end_empty", rd_empty, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fifo_64i_32o_dwc.md
FIFO_64I_32O_DWC -- requirements
Module: fifo_64i_32o_dwc

Interface
REQ-001 Parameter WR_DEPTH_WIDTH, default 9: log2 of the storage depth in 64-bit words (512 words).
REQ-002 Parameter ALMOST_FULL_NUM, default 508: wr_water_level threshold for almost_full, in 64-bit words.
REQ-003 Parameter ALMOST_EMPTY_NUM, default 4: rd_water_level threshold for almost_empty, in 32-bit words.
REQ-004 clk  in  1  single clock for the write and read sides.
REQ-005 tb_rst  in  1  reset: asynchronous, active-high.
REQ-006 wr_data  in  64  write word.
REQ-007 wr_en  in  1  write request.
REQ-008 wr_full  out  1  storage holds 2^WR_DEPTH_WIDTH words.
REQ-009 wr_water_level  out  WR_DEPTH_WIDTH+1  occupied 64-bit words; a partly read word counts as occupied.
REQ-010 almost_full  out  1  wr_water_level >= ALMOST_FULL_NUM.
REQ-011 rd_en  in  1  read request for one 32-bit half-word.
REQ-012 rd_data  out  32  read half-word.
REQ-013 rd_empty  out  1  no unread half-words.
REQ-014 rd_water_level  out  WR_DEPTH_WIDTH+2  unread 32-bit half-words.
REQ-015 almost_empty  out  1  rd_water_level <= ALMOST_EMPTY_NUM.

Function
REQ-016 A write SHALL be accepted on a clk edge when wr_en=1 and wr_full=0; wr_en with wr_full=1 SHALL be ignored with no state change.
REQ-017 A read SHALL be accepted when rd_en=1 and rd_empty=0; rd_en with rd_empty=1 SHALL be ignored.
REQ-018 Full and empty SHALL be evaluated from the pre-edge state: a same-cycle read SHALL NOT let a write through while full, and a same-cycle write SHALL NOT let a read through while empty.
REQ-019 Each 64-bit word SHALL be read as two half-words: first wr_data[31:0], then wr_data[63:32].
REQ-020 rd_data SHALL update on the clk edge that accepts a read (one-cycle latency from rd_en) and SHALL hold its value otherwise.
REQ-021 The write pointer SHALL be WR_DEPTH_WIDTH+1 bits and the read pointer WR_DEPTH_WIDTH+2 bits (half-word granularity). Both SHALL wrap modulo 2^width, with the extra MSB used for the full/empty distinction.
REQ-022 rd_water_level SHALL equal (2*wr_ptr - rd_ptr) mod 2^(WR_DEPTH_WIDTH+2).
REQ-023 wr_water_level SHALL equal (wr_ptr - rd_ptr[MSB:1]) mod 2^(WR_DEPTH_WIDTH+1).
REQ-024 wr_full SHALL equal (wr_water_level == 2^WR_DEPTH_WIDTH), and rd_empty SHALL equal (rd_water_level == 0).
REQ-025 All flags and levels SHALL be combinational from the registered pointers, so they reflect an accepted access in the cycle after its edge.
REQ-026 A word's storage slot SHALL be released only after its upper half is read.
REQ-027 Simultaneous accepted read and write SHALL leave rd_water_level +1 (2 written, 1 read).

Reset
REQ-028 While tb_rst=1, the following values SHALL apply immediately without waiting for a clk edge:
- both pointers = 0, rd_data = 32'h0;
- rd_empty = 1, almost_empty = 1;
- wr_full = 0, almost_full = 0;
- both water levels = 0.
REQ-029 Reset asserted mid-operation SHALL discard all stored contents; storage RAM contents need not be cleared.

Structure
REQ-030 Shared package fifo_dwc_pkg SHALL hold the data widths (64/32), the depth constants and the pointer-width derivations.
REQ-031 A single sub-module, fifo_dwc_sdpram, SHALL provide the 2^WR_DEPTH_WIDTH x 64 simple dual-port RAM with registered 64-bit read. The top level SHALL register the half-select bit and mux the output half.

Verification
REQ-032 Reset check: assert tb_rst for 200 ns -> rd_empty=1, almost_empty=1, wr_full=0, almost_full=0, both levels=0, rd_data=0.
REQ-033 Single word: write 64'hA5A5_0001_5A5A_0002.
- after the write -> rd_water_level=2;
- after the first read -> rd_data=32'h5A5A_0002, wr_water_level=1;
- after the second read -> rd_data=32'hA5A5_0001, rd_empty=1.
REQ-034 Fill: write 513 words 64'hFFFF_FFFF_FFFF_FFFF down-counting.
- wr_full=1 after word 512, and word 513 is dropped;
- almost_full is high from level 508;
- reading 1024 half-words returns the low/high halves in order; the 1025th read leaves rd_data unchanged.
REQ-035 Wrap: three full fill/drain passes -> no data mismatches, with pointers crossing the MSB.
REQ-036 Concurrent: at level 10, assert wr_en and rd_en together for 50 cycles -> rd_water_level rises by 1 per cycle and data order is preserved.
REQ-037 Mid-operation reset: with 100 words stored and reads active, pulse tb_rst -> rd_empty=1 immediately; the next write/read pair returns the new data.
